// File: rtl/dec_display_scan.sv
// rtl/dec_display_scan.sv - frame-snapshotted, time-multiplexed 7-segment scanner
// Optional: SEG_LZB_EN enables leading-zero blanking.
module dec_display_scan #(
    parameter int NDIG       = 4,
    parameter int PRESCALE   = 1000,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic [4*NDIG-1:0]   digits_in,
    output logic [6:0]          seg,
    output logic [NDIG-1:0]     an,
    output logic                frame_start
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [PW-1:0]   PRE_MAX = PW'(PRESCALE - 1);
    localparam logic [IW-1:0]   IDX_MAX = IW'(NDIG - 1);
    localparam logic [6:0]      SEG_OFF = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [NDIG-1:0] AN_OFF  = (ACTIVE_LOW != 0) ? {NDIG{1'b1}} : {NDIG{1'b0}};

    logic [PW-1:0]     pre_cnt;
    logic [IW-1:0]     dig_idx;
    logic [4*NDIG-1:0] frame;
    logic              primed;
    logic              tick;
    logic              load;
    logic [3:0]        cur_code;
    logic [6:0]        seg_pat;
    logic [NDIG-1:0]   an_hot;

    function automatic logic [6:0] glyph(input logic [3:0] code);
        case (code)
            4'd0:    glyph = 7'h3F;
            4'd1:    glyph = 7'h06;
            4'd2:    glyph = 7'h5B;
            4'd3:    glyph = 7'h4F;
            4'd4:    glyph = 7'h66;
            4'd5:    glyph = 7'h6D;
            4'd6:    glyph = 7'h7D;
            4'd7:    glyph = 7'h07;
            4'd8:    glyph = 7'h7F;
            4'd9:    glyph = 7'h6F;
            default: glyph = 7'h40;
        endcase
    endfunction

    assign tick     = (pre_cnt == PRE_MAX);
    assign load     = en && (!primed || (tick && dig_idx == IDX_MAX));
    assign cur_code = frame[{dig_idx, 2'b00} +: 4];

    always_comb begin
        an_hot = '0;
        for (int i = 0; i < NDIG; i++) begin
            an_hot[i] = (dig_idx == IW'(i));
        end
    end

`ifdef SEG_LZB_EN
    logic [NDIG-1:0] lzb_mask;
    logic [NDIG-1:0] lzb_next;

    // A digit is blanked while every digit from the top down to it is zero.
    always_comb begin
        logic run;
        run      = 1'b1;
        lzb_next = '0;
        for (int i = NDIG - 1; i >= 0; i--) begin
            run         = run && (digits_in[4*i +: 4] == 4'd0);
            lzb_next[i] = run && (i != 0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lzb_mask <= '0;
        end else if (load) begin
            lzb_mask <= lzb_next;
        end
    end

    always_comb begin
        seg_pat = lzb_mask[dig_idx] ? 7'h00 : glyph(cur_code);
    end
`else
    always_comb begin
        seg_pat = glyph(cur_code);
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            pre_cnt     <= '0;
            dig_idx     <= '0;
            frame       <= '0;
            primed      <= 1'b0;
            frame_start <= 1'b0;
            seg         <= SEG_OFF;
            an          <= AN_OFF;
        end else begin
            frame_start <= load;
            if (load) begin
                frame <= digits_in;
            end
            if (en && !primed) begin
                primed <= 1'b1;
            end else if (en) begin
                pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
                if (tick) begin
                    dig_idx <= (dig_idx == IDX_MAX) ? '0 : dig_idx + 1'b1;
                end
            end
            // Outputs reflect the state before this edge: one cycle of latency.
            if (en && primed) begin
                seg <= (ACTIVE_LOW != 0) ? ~seg_pat : seg_pat;
                an  <= (ACTIVE_LOW != 0) ? ~an_hot : an_hot;
            end else begin
                seg <= SEG_OFF;
                an  <= AN_OFF;
            end
        end
    end
endmodule
